fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch back end of IF, directly downstream of the thread controller. Each cycle it takes the selected thread and its PC, issues an instruction-memory request, and returns PC+4 to that thread's CSR on acceptance. It tracks in-flight requests in an in-order tagged ring buffer and drops results belonging to killed or slept threads. It presents {thread, pc, instruction} to decode over a valid/ready handshake.

## Interface
- DEPTH, 4, ring-buffer entries and maximum in-flight plus buffered fetches; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cur_trd  in  3  thread selected by the thread controller this cycle
- cur_pc  in  32  PC of cur_trd
- fetch_en  in  1  cur_trd is valid and running; fetch permitted
- flush  in  1  discard every fetch belonging to flush_trd
- flush_trd  in  3  thread being flushed
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  request address (= cur_pc)
- imem_rsp_valid  in  1  response valid; in order; no backpressure
- imem_rsp_data  in  32  instruction word
- pc_wr  out  8  one-hot write strobe to thread CSR PC
- nxt_pc  out  32  value written on pc_wr
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts
- if_trd  out  3  thread of the instruction
- if_pc  out  32  PC of the instruction
- if_instr  out  32  instruction word
- rsp_err  out  1  sticky: response received with nothing outstanding

## Operation
- Ring of DEPTH entries {trd, pc, instr, filled, killed}; pointers alloc_ptr, fill_ptr, head_ptr ($clog2(DEPTH) bits, natural wrap); occupancy count 0..DEPTH.
- Issue: imem_req_valid = fetch_en & (count < DEPTH) & ~(flush & flush_trd == cur_trd). On req_valid & req_ready: write {cur_trd, cur_pc, filled=0, killed=0} at alloc_ptr, advance alloc_ptr, count+1, pc_wr[cur_trd]=1, nxt_pc = cur_pc + 32'd4 (mod 2^32). Otherwise pc_wr = 0.
- Response: on imem_rsp_valid with an outstanding entry: write instr, set filled at fill_ptr, advance fill_ptr. If nothing is outstanding, ignore the response and set rsp_err.
- Flush: set killed on every allocated entry whose trd == flush_trd, covering outstanding and filled entries.
- Head: if_valid = head filled & ~killed & ~(flush & flush_trd == head trd). A filled and killed head is popped silently in one cycle. A pop on if_valid & if_ready frees the entry: head_ptr+1, count-1.
- Simultaneous alloc and pop in one cycle leave count unchanged. Full occupancy (count == DEPTH) only blocks issue; responses always have a slot because of the credit scheme.
- A flush arriving in the same cycle as the response for a matching entry leaves that entry killed.

## Timing
- Reset values: imem_req_valid, pc_wr, if_valid, rsp_err, count, and all pointers are 0. All valid/killed/filled bits are cleared. Data outputs are 0.
- Reset mid-operation discards all entries. Responses to requests issued before reset are then seen with nothing outstanding and set rsp_err. The integration resets memory together with this block.
- Request path is combinational: issue decision and pc_wr occur in the same cycle as cur_trd/cur_pc.
- Response in cycle N gives if_valid in cycle N+1 when the entry is head. Minimum request-to-decode latency is 2 cycles with single-cycle memory.
- Throughput is one fetch per cycle with single-cycle memory and if_ready high.
- if_* are held stable while if_valid & ~if_ready, unless a flush of that thread drops the entry.

## Structure
- Shared package: NUM_TRD=8, TRD_W=3, XLEN=32, and typedef fetch_entry_t {trd, pc, instr, filled, killed}.
- No sub-module. The ring buffer is inline because per-entry killed marking does not fit a generic FIFO.

## Test plan
- Reset, then fetch_en=1, trd 2, pc 0x100, 1-cycle memory returning 0xDEADBEEF: pc_wr=8'b0000_0100 and nxt_pc=0x104 in the issue cycle; if_valid two cycles later with trd 2, pc 0x100, instr 0xDEADBEEF.
- if_ready=0, continuous issue with 1-cycle memory (DEPTH=4): exactly 4 requests accepted, then imem_req_valid=0 and pc_wr=0; after one pop, exactly one further request is accepted.
- Threads 1,3,1 in flight; flush trd 1 before responses: only the trd 3 instruction reaches decode; count returns to 0.
- Flush trd 5 in the same cycle cur_trd=5: imem_req_valid=0, pc_wr=0.
- imem_rsp_valid pulse with count=0: rsp_err=1 and stays 1 until rst; no if_valid.
- pc 0xFFFFFFFC accepted: nxt_pc=0x00000000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths and ring-entry type for the fetch unit.
package fetch_unit_pkg;
  localparam int NUM_TRD = 8;
  localparam int TRD_W = 3;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [TRD_W-1:0] trd;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic             filled;
    logic             killed;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: issues imem requests for the selected thread and returns instructions in order via a tagged ring.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TRD_W-1:0]   cur_trd,
  input  logic [XLEN-1:0]    cur_pc,
  input  logic               fetch_en,
  input  logic               flush,
  input  logic [TRD_W-1:0]   flush_trd,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [XLEN-1:0]    imem_rsp_data,
  output logic [NUM_TRD-1:0] pc_wr,
  output logic [XLEN-1:0]    nxt_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [TRD_W-1:0]   if_trd,
  output logic [XLEN-1:0]    if_pc,
  output logic [XLEN-1:0]    if_instr,
  output logic               rsp_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  fetch_entry_t ring_q [DEPTH];
  fetch_entry_t ring_d [DEPTH];
  fetch_entry_t head;
  logic [PW-1:0] head_q, head_d, alloc_q, alloc_d, fill_q, fill_d, off;
  logic [CW-1:0] count_q, count_d, out_q, out_d;
  logic [DEPTH-1:0] live;
  logic err_q, err_d, acc, rsp_ok, pop;
  assign head = ring_q[head_q];
  assign imem_req_valid = fetch_en & (count_q < CW'(DEPTH)) & ~(flush & (flush_trd == cur_trd));
  assign acc = imem_req_valid & imem_req_ready;
  assign imem_addr = cur_pc;
  assign pc_wr = acc ? NUM_TRD'(1) << cur_trd : '0;
  assign nxt_pc = cur_pc + XLEN'(4);
  // out_q counts requests still awaiting a response, so a stray response is detectable.
  assign rsp_ok = imem_rsp_valid & (out_q != '0);
  assign if_valid = head.filled & ~head.killed & ~(flush & (flush_trd == head.trd));
  assign pop = head.filled & (head.killed | (if_valid & if_ready));
  assign if_trd = head.trd;
  assign if_pc = head.pc;
  assign if_instr = head.instr;
  assign rsp_err = err_q;
  assign head_d = head_q + PW'(pop);
  assign alloc_d = alloc_q + PW'(acc);
  assign fill_d = fill_q + PW'(rsp_ok);
  assign count_d = count_q + CW'(acc) - CW'(pop);
  assign out_d = out_q + CW'(acc) - CW'(rsp_ok);
  assign err_d = err_q | (imem_rsp_valid & (out_q == '0));
  always_comb begin
    off = '0;
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      live[i] = {1'b0, off} < count_q;
    end
  end
  always_comb begin
    ring_d = ring_q;
    for (int i = 0; i < DEPTH; i++)
      if (flush && live[i] && ring_q[i].trd == flush_trd) ring_d[i].killed = 1'b1;
    if (rsp_ok) begin
      ring_d[fill_q].instr = imem_rsp_data;
      ring_d[fill_q].filled = 1'b1;
    end
    if (pop) begin
      ring_d[head_q].filled = 1'b0;
      ring_d[head_q].killed = 1'b0;
    end
    if (acc) ring_d[alloc_q] = '{trd: cur_trd, pc: cur_pc, instr: '0, filled: 1'b0, killed: 1'b0};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      head_q <= '0;
      alloc_q <= '0;
      fill_q <= '0;
      count_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      ring_q <= ring_d;
      head_q <= head_d;
      alloc_q <= alloc_d;
      fill_q <= fill_d;
      count_q <= count_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven request-path vectors plus hand sequences for latency, backpressure, flush and stray responses.
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] cur_trd = '0, flush_trd = '0, if_trd;
  logic [31:0] cur_pc = '0, imem_addr, imem_rsp_data, nxt_pc, if_pc, if_instr;
  logic fetch_en = 1'b0, flush = 1'b0, imem_req_valid, imem_req_ready = 1'b1;
  logic imem_rsp_valid, if_valid, if_ready = 1'b0, rsp_err;
  logic [7:0] pc_wr;
  logic mem_hold = 1'b0, stray = 1'b0;
  int checks = 0, failures = 0;
  logic [31:0] q[$];

  fetch_unit #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cur_trd(cur_trd), .cur_pc(cur_pc), .fetch_en(fetch_en),
    .flush(flush), .flush_trd(flush_trd), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .pc_wr(pc_wr), .nxt_pc(nxt_pc), .if_valid(if_valid),
    .if_ready(if_ready), .if_trd(if_trd), .if_pc(if_pc), .if_instr(if_instr), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : a ^ 32'h5A5A_0000;
  endfunction

  // single-cycle in-order memory; mem_hold stalls responses, stray forces one unsolicited response
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) q.push_back(imem_addr);
      if (stray) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data <= 32'h0BAD_0BAD;
      end else if (!mem_hold && q.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data <= mem_data(q.pop_front());
      end else imem_rsp_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_en = 1'b0;
    flush = 1'b0;
    if_ready = 1'b0;
    mem_hold = 1'b0;
    stray = 1'b0;
    imem_req_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    fetch_en = 1'b0;
    flush = 1'b0;
    mem_hold = 1'b0;
    if_ready = 1'b1;
    repeat (8) step();
  endtask

  typedef struct {
    logic en; logic [2:0] trd; logic [31:0] pc; logic fl; logic [2:0] ftrd; logic rdy;
    logic exp_req; logic [7:0] exp_wr; logic [31:0] exp_nxt;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int acc, seen;
    logic [31:0] seen_pc;
    logic [2:0] seen_trd;
    vecs[0] = '{1'b1, 3'd2, 32'h0000_0100, 1'b0, 3'd0, 1'b1, 1'b1, 8'b0000_0100, 32'h0000_0104};
    vecs[1] = '{1'b0, 3'd2, 32'h0000_0200, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 32'h0};
    vecs[2] = '{1'b1, 3'd5, 32'h0000_0300, 1'b1, 3'd5, 1'b1, 1'b0, 8'h00, 32'h0};
    vecs[3] = '{1'b1, 3'd5, 32'h0000_0304, 1'b1, 3'd4, 1'b1, 1'b1, 8'b0010_0000, 32'h0000_0308};
    vecs[4] = '{1'b1, 3'd7, 32'hFFFF_FFFC, 1'b0, 3'd0, 1'b1, 1'b1, 8'b1000_0000, 32'h0000_0000};
    vecs[5] = '{1'b1, 3'd0, 32'h0000_0400, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 32'h0};
    vecs[6] = '{1'b1, 3'd3, 32'h0000_2000, 1'b0, 3'd0, 1'b1, 1'b1, 8'b0000_1000, 32'h0000_2004};

    do_reset();
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc_wr", 32'(pc_wr), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);

    if_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fetch_en = vecs[i].en;
      cur_trd = vecs[i].trd;
      cur_pc = vecs[i].pc;
      flush = vecs[i].fl;
      flush_trd = vecs[i].ftrd;
      imem_req_ready = vecs[i].rdy;
      #2;
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_pc_wr", i), 32'(pc_wr), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr != 8'h00) chk($sformatf("vec%0d_nxt_pc", i), nxt_pc, vecs[i].exp_nxt);
      step();
    end
    imem_req_ready = 1'b1;
    drain();

    // issue-to-decode latency and hold under backpressure
    do_reset();
    fetch_en = 1'b1;
    cur_trd = 3'd2;
    cur_pc = 32'h100;
    step();
    fetch_en = 1'b0;
    #1;
    chk("lat_n1_if_valid", 32'(if_valid), 32'd0);
    step();
    if_ready = 1'b0;
    #1;
    chk("lat_n2_if_valid", 32'(if_valid), 32'd1);
    chk("lat_if_trd", 32'(if_trd), 32'd2);
    chk("lat_if_pc", if_pc, 32'h100);
    chk("lat_if_instr", if_instr, 32'hDEAD_BEEF);
    step();
    chk("hold_if_valid", 32'(if_valid), 32'd1);
    chk("hold_if_pc", if_pc, 32'h100);
    if_ready = 1'b1;
    step();
    chk("pop_if_valid", 32'(if_valid), 32'd0);

    // full occupancy blocks issue; one pop frees exactly one slot
    do_reset();
    acc = 0;
    fetch_en = 1'b1;
    cur_trd = 3'd1;
    for (int k = 0; k < 8; k++) begin
      cur_pc = 32'h400 + 32'(4 * k);
      #1;
      if (imem_req_valid && imem_req_ready) acc++;
      step();
    end
    chk("full_accepts", 32'(acc), 32'd4);
    #1;
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    chk("full_pc_wr", 32'(pc_wr), 32'd0);
    if_ready = 1'b1;
    #1;
    chk("full_head_valid", 32'(if_valid), 32'd1);
    chk("full_head_pc", if_pc, 32'h400);
    acc = (imem_req_valid && imem_req_ready) ? 1 : 0;
    step();
    if_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cur_pc = 32'h500 + 32'(4 * k);
      #1;
      if (imem_req_valid && imem_req_ready) acc++;
      step();
    end
    chk("after_pop_accepts", 32'(acc), 32'd1);
    drain();

    // flush kills in-flight entries of one thread only
    do_reset();
    mem_hold = 1'b1;
    fetch_en = 1'b1;
    cur_trd = 3'd1; cur_pc = 32'h10; step();
    cur_trd = 3'd3; cur_pc = 32'h20; step();
    cur_trd = 3'd1; cur_pc = 32'h30; step();
    fetch_en = 1'b0;
    flush = 1'b1;
    flush_trd = 3'd1;
    step();
    flush = 1'b0;
    mem_hold = 1'b0;
    if_ready = 1'b1;
    seen = 0;
    seen_pc = '0;
    seen_trd = '0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (if_valid) begin
        seen++;
        seen_pc = if_pc;
        seen_trd = if_trd;
      end
      step();
    end
    chk("flush_delivered", 32'(seen), 32'd1);
    chk("flush_pc", seen_pc, 32'h20);
    chk("flush_trd", 32'(seen_trd), 32'd3);
    if_ready = 1'b0;
    acc = 0;
    fetch_en = 1'b1;
    cur_trd = 3'd6;
    for (int k = 0; k < 6; k++) begin
      cur_pc = 32'h800 + 32'(4 * k);
      #1;
      if (imem_req_valid && imem_req_ready) acc++;
      step();
    end
    chk("flush_count_empty", 32'(acc), 32'd4);
    drain();

    // unsolicited response sets sticky error until reset
    do_reset();
    stray = 1'b1;
    step();
    stray = 1'b0;
    step();
    chk("stray_rsp_err", 32'(rsp_err), 32'd1);
    chk("stray_if_valid", 32'(if_valid), 32'd0);
    repeat (3) step();
    chk("stray_sticky", 32'(rsp_err), 32'd1);
    do_reset();
    #1;
    chk("stray_cleared", 32'(rsp_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
